// File: rtl/scaler_dsp_pkg.sv
// Shared width arithmetic and the fixed-point round/saturate helper for the
// scaler DSP path.
package scaler_dsp_pkg;

   // Ceiling log2; clog2(1) = 0 so a single-tap kernel needs no adder levels.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Product width: zero-extended pixel times signed coefficient always fits.
   function automatic int mult_w(input int pb, input int kcb);
      return pb + kcb;
   endfunction

   // Tree sum width: one growth bit per pairwise adder level.
   function automatic int sum_w(input int pb, input int kcb, input int k);
      return mult_w(pb, kcb) + clog2(k);
   endfunction

   // Cycles from an accepted beat to its result: input, product, tree, output.
   function automatic int latency(input int k);
      return 3 + clog2(k);
   endfunction

   // Number of operands left at a given adder-tree level (odd ones pass up).
   function automatic int tree_count(input int n, input int lvl);
      int c;
      c = n;
      for (int i = 0; i < lvl; i++) c = (c + 1) / 2;
      return c;
   endfunction

   // Round half up, drop the coefficient fraction, clamp to [0, 2^pb-1].
   function automatic logic [31:0] round_sat(input logic signed [63:0] sum,
                                             input int frac, input int pb);
      logic signed [63:0] r;
      logic signed [63:0] max_v;
      max_v = (64'sd1 <<< pb) - 64'sd1;
      r     = (sum + (64'sd1 <<< (frac - 1))) >>> frac;
      if (r < 0)          return '0;
      else if (r > max_v) return max_v[31:0];
      else                return r[31:0];
   endfunction

endpackage

// File: rtl/scaler_mac_tree_add_tree.sv
// Pipelined pairwise adder tree: N_IN signed operands reduced over
// clog2(N_IN) registered levels. An odd leftover operand is carried up a
// level unchanged. With N_IN = 1 the tree is a plain sign extension.
module scaler_add_tree
   import scaler_dsp_pkg::*;
#(
   parameter int N_IN  = 4,
   parameter int IN_W  = 16,
   parameter int OUT_W = 18
) (
   input  logic                   clk,
   input  logic                   en,
   input  logic [N_IN*IN_W-1:0]   din,
   output logic [OUT_W-1:0]       dout
);

   localparam int T = clog2(N_IN);

   for (genvar l = 0; l <= T; l++) begin : g_lvl
      localparam int CNT = tree_count(N_IN, l);
      logic signed [OUT_W-1:0] node [CNT];

      if (l == 0) begin : g_leaf
         for (genvar i = 0; i < CNT; i++) begin : g_in
            // Leaves: sign-extend each product to the full sum width.
            assign node[i] = OUT_W'(signed'(din[i*IN_W +: IN_W]));
         end
      end else begin : g_add
         for (genvar i = 0; i < CNT; i++) begin : g_node
            if (2 * i + 1 < tree_count(N_IN, l - 1)) begin : g_pair
               // Pairwise add of two operands from the level below.
               always_ff @(posedge clk) begin
                  if (en) node[i] <= g_lvl[l-1].node[2*i] + g_lvl[l-1].node[2*i+1];
               end
            end else begin : g_pass
               // Odd operand: carried up one level so all paths stay aligned.
               always_ff @(posedge clk) begin
                  if (en) node[i] <= g_lvl[l-1].node[2*i];
               end
            end
         end
      end
   end

   assign dout = g_lvl[T].node[0];

endmodule

// File: rtl/scaler_mac_tree.sv
// Multi-channel MAC filter: per-channel dot product of KERNEL_MAX pixels with
// a shared signed coefficient set, pipelined adder tree, round/saturate.
// Optional build macro SCALER_MAC_SELFCHECK_EN adds a simulation-only
// behavioural checker (err_flag); ports are identical either way.
module scaler_mac_tree
   import scaler_dsp_pkg::*;
#(
   parameter  int PIXEL_BITWIDTH       = 8,
   parameter  int KERNEL_MAX           = 4,
   parameter  int KERNEL_COEF_BITWIDTH = 8,
   parameter  int COEF_FRAC            = 6,
   parameter  int CHANNEL_NUM          = 2,
   localparam int SUM_W = sum_w(PIXEL_BITWIDTH, KERNEL_COEF_BITWIDTH, KERNEL_MAX)
) (
   input  logic                                              clk,
   input  logic                                              rst,
   input  logic                                              din_valid,
   output logic                                              din_ready,
   input  logic [KERNEL_MAX*KERNEL_COEF_BITWIDTH-1:0]        din_coef,
   input  logic [CHANNEL_NUM*KERNEL_MAX*PIXEL_BITWIDTH-1:0]  din_pixel,
   output logic                                              dout_valid,
   input  logic                                              dout_ready,
   output logic [CHANNEL_NUM*PIXEL_BITWIDTH-1:0]             dout_pixel,
   output logic [CHANNEL_NUM*SUM_W-1:0]                      dout_sum
);

   localparam int PB  = PIXEL_BITWIDTH;
   localparam int KCB = KERNEL_COEF_BITWIDTH;
   localparam int K   = KERNEL_MAX;
   localparam int C   = CHANNEL_NUM;
   localparam int MW  = mult_w(PB, KCB);
   localparam int T   = clog2(K);

   // One global enable: a stalled output freezes every stage, bubbles included.
   logic stall;
   logic en;
   assign stall     = dout_valid & ~dout_ready;
   assign en        = ~stall;
   assign din_ready = en;

   logic                 s0_valid;
   logic [K*KCB-1:0]     s0_coef;
   logic [C*K*PB-1:0]    s0_pixel;
   logic                 s1_valid;
   logic [C*K*MW-1:0]    s1_prod;
   logic [T:0]           tree_valid;
   logic [C*SUM_W-1:0]   tree_sum;

   // Stage valid chain for input and product registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s0_valid <= 1'b0;
         s1_valid <= 1'b0;
      end else if (en) begin
         s0_valid <= din_valid;
         s1_valid <= s0_valid;
      end
   end

   // S0: capture the accepted beat.
   // NOTE: datapath registers have no reset; the valid bit that travels with
   // them is the only thing that gives their contents meaning.
   always_ff @(posedge clk) begin
      if (en && din_valid) begin
         s0_coef  <= din_coef;
         s0_pixel <= din_pixel;
      end
   end

   // S1: signed products, pixel zero-extended, both operands widened first.
   always_ff @(posedge clk) begin
      if (en && s0_valid) begin
         for (int c = 0; c < C; c++) begin
            for (int k = 0; k < K; k++) begin
               s1_prod[(c*K+k)*MW +: MW] <=
                  MW'(signed'({1'b0, s0_pixel[(c*K+k)*PB +: PB]})) *
                  MW'(signed'(s0_coef[k*KCB +: KCB]));
            end
         end
      end
   end

   for (genvar c = 0; c < C; c++) begin : g_ch
      scaler_add_tree #(
         .N_IN  (K),
         .IN_W  (MW),
         .OUT_W (SUM_W)
      ) u_tree (
         .clk  (clk),
         .en   (en),
         .din  (s1_prod[c*K*MW +: K*MW]),
         .dout (tree_sum[c*SUM_W +: SUM_W])
      );
   end

   assign tree_valid[0] = s1_valid;
   for (genvar l = 1; l <= T; l++) begin : g_tv
      // Valid bit shadowing each adder-tree level.
      always_ff @(posedge clk or posedge rst) begin
         if (rst)     tree_valid[l] <= 1'b0;
         else if (en) tree_valid[l] <= tree_valid[l-1];
      end
   end

   // Final stage: register raw sum and rounded/saturated pixel per channel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout_valid <= 1'b0;
         dout_pixel <= '0;
         dout_sum   <= '0;
      end else if (en) begin
         dout_valid <= tree_valid[T];
         if (tree_valid[T]) begin
            for (int c = 0; c < C; c++) begin
               dout_sum[c*SUM_W +: SUM_W] <= tree_sum[c*SUM_W +: SUM_W];
               dout_pixel[c*PB +: PB] <= PB'(round_sat(
                  64'(signed'(tree_sum[c*SUM_W +: SUM_W])), COEF_FRAC, PB));
            end
         end
      end
   end

`ifdef SCALER_MAC_SELFCHECK_EN
   logic   err_flag;
   longint model_q[$];
   longint acc;
   longint exp_sum;
   logic [PB-1:0] exp_pix;

   // Behavioural reference: score each accepted beat, compare each delivered one.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         model_q.delete();
         err_flag <= 1'b0;
      end else begin
         if (dout_valid && dout_ready) begin
            for (int c = 0; c < C; c++) begin
               if (model_q.size() == 0) begin
                  err_flag <= 1'b1;
                  $error("scaler_mac_tree: output beat with no accepted input");
               end else begin
                  exp_sum = model_q.pop_front();
                  exp_pix = PB'(round_sat(64'(exp_sum), COEF_FRAC, PB));
                  if (exp_sum != longint'(signed'(dout_sum[c*SUM_W +: SUM_W])) ||
                      exp_pix != dout_pixel[c*PB +: PB]) begin
                     err_flag <= 1'b1;
                     $error("scaler_mac_tree: channel %0d sum %0d pixel %0d, model %0d %0d",
                            c, signed'(dout_sum[c*SUM_W +: SUM_W]),
                            dout_pixel[c*PB +: PB], exp_sum, exp_pix);
                  end
               end
            end
         end
         if (din_valid && din_ready) begin
            for (int c = 0; c < C; c++) begin
               acc = 0;
               for (int k = 0; k < K; k++) begin
                  acc = acc + longint'(din_pixel[(c*K+k)*PB +: PB]) *
                              longint'(signed'(din_coef[k*KCB +: KCB]));
               end
               model_q.push_back(acc);
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_scaler_mac_tree.sv
// Directed and model-checked bench for scaler_mac_tree: reset state, hand
// vectors, rounding/saturation boundaries, backpressure, tap-count sweep and
// reset with beats in flight.
module tb_scaler_mac_tree;

   localparam int PB  = 8;
   localparam int KCB = 8;
   localparam int K   = 4;
   localparam int C   = 2;
   localparam int SW  = 18;

   logic               clk;
   logic               rst;
   logic               din_valid;
   logic               din_ready;
   logic [K*KCB-1:0]   din_coef;
   logic [C*K*PB-1:0]  din_pixel;
   logic               dout_valid;
   logic               dout_ready;
   logic [C*PB-1:0]    dout_pixel;
   logic [C*SW-1:0]    dout_sum;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   bit sweep_go = 0;

   scaler_mac_tree #(
      .PIXEL_BITWIDTH       (PB),
      .KERNEL_MAX           (K),
      .KERNEL_COEF_BITWIDTH (KCB),
      .COEF_FRAC            (6),
      .CHANNEL_NUM          (C)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .din_coef   (din_coef),
      .din_pixel  (din_pixel),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .dout_pixel (dout_pixel),
      .dout_sum   (dout_sum)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic signed [63:0] got,
                        input logic signed [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference dot product for channel ch with kk taps, 8-bit fields.
   function automatic longint model_sum(input int kk, input logic [63:0] coef,
                                        input logic [127:0] pix, input int ch);
      longint s;
      s = 0;
      for (int k = 0; k < kk; k++)
         s += longint'(pix[(ch*kk+k)*8 +: 8]) * longint'(signed'(coef[k*8 +: 8]));
      return s;
   endfunction

   // Round half up by 2^6, clamp to 0..255.
   function automatic longint model_pix(input longint s);
      longint r;
      r = (s + 32) >>> 6;
      if (r < 0)   r = 0;
      if (r > 255) r = 255;
      return r;
   endfunction

   function automatic logic [31:0] pack_coef(input int c0, input int c1,
                                             input int c2, input int c3);
      return {8'(c3), 8'(c2), 8'(c1), 8'(c0)};
   endfunction

   function automatic logic [63:0] pack_pix(input int p0, input int p1);
      return {{4{8'(p1)}}, {4{8'(p0)}}};
   endfunction

   // One beat into an idle pipe; hand-computed sums/pixels and latency 5.
   task automatic directed(input string tag, input logic [31:0] coef,
                           input logic [63:0] pix, input longint es0,
                           input longint es1, input int ep0, input int ep1);
      int  c0;
      bit  seen;
      @(negedge clk);
      dout_ready = 1'b1;
      din_coef   = coef;
      din_pixel  = pix;
      din_valid  = 1'b1;
      c0         = cyc;
      @(negedge clk);
      din_valid = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         if (dout_valid) begin
            seen = 1'b1;
            check({tag, " latency"}, cyc - c0, 5);
            check({tag, " sum0"}, signed'(dout_sum[SW-1:0]), es0);
            check({tag, " sum1"}, signed'(dout_sum[2*SW-1:SW]), es1);
            check({tag, " pix0"}, dout_pixel[7:0], ep0);
            check({tag, " pix1"}, dout_pixel[15:8], ep1);
         end else begin
            @(negedge clk);
         end
      end
      if (!seen) check({tag, " timeout"}, 0, 1);
   endtask

   // Back-to-back random beats; dout_ready low 3 of every 5 cycles.
   task automatic stream_bp(input int nb);
      longint            exp_q[$];
      logic [K*KCB-1:0]  cf;
      logic [C*K*PB-1:0] px;
      logic [C*PB-1:0]   h_pix;
      logic [C*SW-1:0]   h_sum;
      longint            es;
      int                sent;
      int                got;
      int                n;
      bit                was_stall;
      sent = 0; got = 0; n = 0; was_stall = 1'b0;
      cf = $urandom; px = {$urandom, $urandom};
      while (got < nb && n < 500) begin
         @(negedge clk);
         dout_ready = (n % 5) >= 3;
         din_valid  = (sent < nb);
         din_coef   = cf;
         din_pixel  = px;
         #1;
         check("bp din_ready", din_ready, !(dout_valid && !dout_ready));
         if (was_stall) begin
            check("bp hold pixel", dout_pixel, h_pix);
            check("bp hold sum", dout_sum, h_sum);
         end
         was_stall = dout_valid && !dout_ready;
         h_pix = dout_pixel;
         h_sum = dout_sum;
         if (dout_valid && dout_ready) begin
            for (int c = 0; c < C; c++) begin
               if (exp_q.size() == 0) begin
                  check("bp extra beat", 1, 0);
               end else begin
                  es = exp_q.pop_front();
                  check("bp sum", signed'(dout_sum[c*SW +: SW]), es);
                  check("bp pixel", dout_pixel[c*PB +: PB], model_pix(es));
               end
            end
            got++;
         end
         if (din_valid && din_ready) begin
            for (int c = 0; c < C; c++) exp_q.push_back(model_sum(K, 64'(cf), 128'(px), c));
            sent++;
            cf = $urandom; px = {$urandom, $urandom};
         end
         n++;
      end
      check("bp beats out", got, nb);
      din_valid  = 1'b0;
      dout_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("bp no duplicate", dout_valid, 0);
      end
   endtask

   // Tap-count sweep: one instance per KERNEL_MAX, each with its own driver.
   for (genvar g = 0; g < 4; g++) begin : g_sweep
      localparam int KS  = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 5 : 8;
      localparam int SWS = (g == 0) ? 16 : (g == 1) ? 18 : 19;
      localparam int LAT = (g == 0) ? 3 : (g == 1) ? 5 : 6;

      logic                s_din_valid;
      logic                s_din_ready;
      logic [KS*KCB-1:0]   s_coef;
      logic [C*KS*PB-1:0]  s_pix;
      logic                s_dout_valid;
      logic                s_dout_ready;
      logic [C*PB-1:0]     s_dout_pixel;
      logic [C*SWS-1:0]    s_dout_sum;
      bit                  done = 1'b0;

      scaler_mac_tree #(
         .PIXEL_BITWIDTH       (PB),
         .KERNEL_MAX           (KS),
         .KERNEL_COEF_BITWIDTH (KCB),
         .COEF_FRAC            (6),
         .CHANNEL_NUM          (C)
      ) dut_sw (
         .clk        (clk),
         .rst        (rst),
         .din_valid  (s_din_valid),
         .din_ready  (s_din_ready),
         .din_coef   (s_coef),
         .din_pixel  (s_pix),
         .dout_valid (s_dout_valid),
         .dout_ready (s_dout_ready),
         .dout_pixel (s_dout_pixel),
         .dout_sum   (s_dout_sum)
      );

      initial begin
         longint exp_q[$];
         longint es;
         int     sent;
         int     got;
         int     n;
         int     c_first;
         string  tg;
         s_din_valid = 1'b0; s_dout_ready = 1'b1; s_coef = '0; s_pix = '0;
         sent = 0; got = 0; n = 0; c_first = 0;
         tg = $sformatf("sweep K%0d", KS);
         wait (sweep_go);
         while (got < 6 && n < 100) begin
            @(negedge clk);
            s_din_valid = (sent < 6);
            if (sent < 6) begin
               for (int k = 0; k < KS; k++) s_coef[k*8 +: 8] = 8'($urandom);
               for (int i = 0; i < C*KS; i++) s_pix[i*8 +: 8] = 8'($urandom);
            end
            #1;
            if (s_dout_valid) begin
               if (got == 0) check({tg, " latency"}, cyc - c_first, LAT);
               for (int c = 0; c < C; c++) begin
                  if (exp_q.size() == 0) begin
                     check({tg, " extra beat"}, 1, 0);
                  end else begin
                     es = exp_q.pop_front();
                     check({tg, " sum"}, signed'(s_dout_sum[c*SWS +: SWS]), es);
                     check({tg, " pixel"}, s_dout_pixel[c*PB +: PB], model_pix(es));
                  end
               end
               got++;
            end
            if (s_din_valid && s_din_ready) begin
               if (sent == 0) c_first = cyc;
               for (int c = 0; c < C; c++)
                  exp_q.push_back(model_sum(KS, 64'(s_coef), 128'(s_pix), c));
               sent++;
            end
            n++;
         end
         check({tg, " beats out"}, got, 6);
         s_din_valid = 1'b0;
         done = 1'b1;
      end
   end

   initial begin
      bit all_done;
      rst        = 1'b1;
      din_valid  = 1'b0;
      dout_ready = 1'b1;
      din_coef   = '0;
      din_pixel  = '0;
      repeat (3) @(negedge clk);
      check("reset dout_valid", dout_valid, 0);
      check("reset dout_pixel", dout_pixel, 0);
      check("reset dout_sum", dout_sum, 0);
      rst = 1'b0;
      #1;
      check("reset din_ready", din_ready, 1);

      directed("unit",   pack_coef(64, 0, 0, 0),   pack_pix(100, 7),   6400,   448,    100, 7);
      directed("avg",    pack_coef(16, 16, 16, 16), pack_pix(200, 200), 12800,  12800,  200, 200);
      directed("round1", pack_coef(1, 0, 0, 0),    pack_pix(32, 31),   32,     31,     1,   0);
      directed("round2", pack_coef(1, 0, 0, 0),    pack_pix(95, 96),   95,     96,     1,   2);
      directed("sat_hi", pack_coef(127, 127, 0, 0), pack_pix(255, 255), 64770,  64770,  255, 255);
      directed("sat_lo", pack_coef(-64, 0, 0, 0),  pack_pix(10, 255),  -640,   -16320, 0,   0);

      stream_bp(20);

      sweep_go = 1'b1;
      all_done = 1'b0;
      for (int n = 0; n < 2000 && !all_done; n++) begin
         @(negedge clk);
         all_done = g_sweep[0].done && g_sweep[1].done && g_sweep[2].done && g_sweep[3].done;
      end
      check("sweep complete", all_done, 1);

      // Three beats in flight, then a one-cycle reset pulse.
      @(negedge clk);
      dout_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         din_valid = 1'b1;
         din_coef  = $urandom;
         din_pixel = {$urandom, $urandom};
         @(negedge clk);
      end
      din_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("rst async dout_valid", dout_valid, 0);
      check("rst async dout_sum", dout_sum, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("rst no stale beat", dout_valid, 0);
      end
      directed("post_rst", pack_coef(64, 0, 0, 0), pack_pix(3, 250), 192, 16000, 3, 250);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
